// File: rtl/tiny_riscv_pkg.sv
// tiny_riscv_pkg: shared types and widths for the tiny RISC-V memory arbiter.
//   state_e   : arbiter FSM states (IDLE=0, ISSUE=1, RESP=2)
//   gnt_e     : grant encoding (GNT_IF=0 fetch port, GNT_D=1 data port)
//   mem_req_t : latched request payload (address, write data, byte mask)
package tiny_riscv_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/tiny_riscv_mem_arbiter_if.sv
// tiny_riscv_mem_arbiter_if: bundles the fetch port, data port and word-memory
// port of the arbiter. Signal names keep the arbiter's port naming.
//   slave  : arbiter side (requests and i_mem_data in, acks/rdata/memory controls out)
//   master : environment side (requesters plus memory)
interface tiny_riscv_mem_arbiter_if;
  import tiny_riscv_pkg::*;

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_ack;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_wmask;
  logic              o_d_ack;
  logic [DATA_W-1:0] o_d_rdata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_read_strobe;
  logic [DATA_W-1:0] o_mem_write_data;
  logic [MASK_W-1:0] o_mem_write_mask;
  logic [DATA_W-1:0] i_mem_data;

  modport slave (
    input  i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_wdata, i_d_wmask, i_mem_data,
    output o_if_ack, o_if_rdata, o_d_ack, o_d_rdata,
    output o_mem_addr, o_read_strobe, o_mem_write_data, o_mem_write_mask
  );

  modport master (
    output i_if_req, i_if_addr, i_d_req, i_d_addr, i_d_wdata, i_d_wmask, i_mem_data,
    input  o_if_ack, o_if_rdata, o_d_ack, o_d_rdata,
    input  o_mem_addr, o_read_strobe, o_mem_write_data, o_mem_write_mask
  );

endinterface

// File: rtl/tiny_riscv_arb_pick.sv
// tiny_riscv_arb_pick: combinational grant decision between fetch and data ports.
//   if_req_i, d_req_i : pending requests
//   ptr_i             : port preferred when both request
//   gnt_c_o           : winning port (meaningful only when a request is present)
module tiny_riscv_arb_pick
  import tiny_riscv_pkg::*;
(
  input  logic if_req_i,
  input  logic d_req_i,
  input  gnt_e ptr_i,
  output gnt_e gnt_c_o
);

  always_comb begin
    gnt_c_o = GNT_IF;
    if (if_req_i && d_req_i) begin
      gnt_c_o = ptr_i;
    end else if (d_req_i) begin
      gnt_c_o = GNT_D;
    end
  end

endmodule

// File: rtl/tiny_riscv_mem_arbiter.sv
// tiny_riscv_mem_arbiter: shares one registered word memory between the
// instruction-fetch and data ports. One access every 3 cycles:
// IDLE (latch winner) -> ISSUE (strobe memory) -> RESP (ack + read data).
//   i_Clk, i_Reset : clock, asynchronous active-high reset
//   bus (slave)    : fetch port, data port, word-memory port
// Build option: TINY_RISCV_ARB_RR_EN selects round-robin on collisions;
// undefined gives fixed data-over-fetch priority with no pointer register.
module tiny_riscv_mem_arbiter
  import tiny_riscv_pkg::*;
(
  input logic                     i_Clk,
  input logic                     i_Reset,
  tiny_riscv_mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  gnt_e              gnt_q, gnt_d;
  gnt_e              pick_gnt;
  gnt_e              ptr;
  logic              load_q, load_d;
  logic              any_req;
  mem_req_t          win;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              read_strobe_q, read_strobe_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;

  assign any_req = bus.i_if_req | bus.i_d_req;

  tiny_riscv_arb_pick u_pick (
    .if_req_i (bus.i_if_req),
    .d_req_i  (bus.i_d_req),
    .ptr_i    (ptr),
    .gnt_c_o  (pick_gnt)
  );

`ifdef TINY_RISCV_ARB_RR_EN
  gnt_e ptr_q, ptr_d;

  // Prefer the port that did not win the last grant.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req) begin
      ptr_d = (pick_gnt == GNT_D) ? GNT_IF : GNT_D;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) ptr_q <= GNT_D;
    else         ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = GNT_D;
`endif

  // Payload of the winning port; fetches are always reads with no write data.
  always_comb begin
    win = '0;
    if (pick_gnt == GNT_D) begin
      win.addr  = bus.i_d_addr;
      win.wdata = bus.i_d_wdata;
      win.wmask = bus.i_d_wmask;
    end else begin
      win.addr  = bus.i_if_addr;
    end
  end

  // Next state and next registered outputs; memory controls are set on the
  // IDLE->ISSUE edge so they are visible exactly during ISSUE.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    load_d        = load_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wmask_d   = '0;
    read_strobe_d = 1'b0;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d       = ST_ISSUE;
          gnt_d         = pick_gnt;
          load_d        = (win.wmask == '0);
          mem_addr_d    = win.addr;
          mem_wdata_d   = win.wdata;
          mem_wmask_d   = win.wmask;
          read_strobe_d = (win.wmask == '0);
        end
      end
      ST_ISSUE: begin
        state_d  = ST_RESP;
        if_ack_d = (gnt_q == GNT_IF);
        d_ack_d  = (gnt_q == GNT_D);
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= ST_IDLE;
      gnt_q         <= GNT_IF;
      load_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wmask_q   <= '0;
      read_strobe_q <= 1'b0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      load_q        <= load_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wmask_q   <= mem_wmask_d;
      read_strobe_q <= read_strobe_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
    end
  end

  assign bus.o_mem_addr       = mem_addr_q;
  assign bus.o_mem_write_data = mem_wdata_q;
  assign bus.o_mem_write_mask = mem_wmask_q;
  assign bus.o_read_strobe    = read_strobe_q;
  assign bus.o_if_ack         = if_ack_q;
  assign bus.o_d_ack          = d_ack_q;

  // Memory data arrives in the RESP cycle itself, so read data is gated, not registered.
  assign bus.o_if_rdata = (if_ack_q && load_q) ? bus.i_mem_data : '0;
  assign bus.o_d_rdata  = (d_ack_q && load_q)  ? bus.i_mem_data : '0;

endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
// Bench for tiny_riscv_mem_arbiter: per-cycle vector table plus hand-written
// reset-abort and sustained-collision sequences, against a small word memory.
module tb_tiny_riscv_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tiny_riscv_mem_arbiter_if bus ();

  tiny_riscv_mem_arbiter dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  // Word memory: registered read, byte-masked write, preloaded during reset.
  logic [31:0] mem_model [0:1023];
  logic [31:0] mem_q = 32'h0;
  logic [9:0]  widx;
  assign widx = bus.o_mem_addr[11:2];
  assign bus.i_mem_data = mem_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 1024; k++) mem_model[k] <= 32'h0;
      mem_model[64]  <= 32'h0000_0013;   // 0x100
      mem_model[65]  <= 32'h0010_0093;   // 0x104
      mem_model[128] <= 32'hCAFE_F00D;   // 0x200
      mem_model[192] <= 32'hA5A5_A5A5;   // 0x300
      mem_model[256] <= 32'h1122_3344;   // 0x400
    end else begin
      if (bus.o_read_strobe) mem_q <= mem_model[widx];
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_write_mask[b]) mem_model[widx][8*b +: 8] <= bus.o_mem_write_data[8*b +: 8];
    end
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        e_strobe;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic        e_if_ack;
    logic [31:0] e_if_rdata;
    logic        e_d_ack;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t tbl [15];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic [31:0] da, input logic [31:0] dw, input logic [3:0] dm,
                              input logic es, input logic [31:0] ea, input logic [31:0] ew,
                              input logic [3:0] em, input logic eia, input logic [31:0] eir,
                              input logic eda, input logic [31:0] edr);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_addr = da;  v.d_wdata = dw;  v.d_wmask = dm;
    v.e_strobe = es; v.e_addr = ea; v.e_wdata = ew; v.e_wmask = em;
    v.e_if_ack = eia; v.e_if_rdata = eir; v.e_d_ack = eda; v.e_d_rdata = edr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [31:0] dw, input logic [3:0] dm);
    bus.i_if_req = ir;  bus.i_if_addr = ia;
    bus.i_d_req = dr;   bus.i_d_addr = da;  bus.i_d_wdata = dw;  bus.i_d_wmask = dm;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " strobe"}, 32'(bus.o_read_strobe), 32'h0);
    chk({tag, " addr"},   bus.o_mem_addr, 32'h0);
    chk({tag, " wdata"},  bus.o_mem_write_data, 32'h0);
    chk({tag, " wmask"},  32'(bus.o_mem_write_mask), 32'h0);
    chk({tag, " if_ack"}, 32'(bus.o_if_ack), 32'h0);
    chk({tag, " d_ack"},  32'(bus.o_d_ack), 32'h0);
    chk({tag, " if_rdata"}, bus.o_if_rdata, 32'h0);
    chk({tag, " d_rdata"},  bus.o_d_rdata, 32'h0);
  endtask

  // Row i: inputs applied before edge i, outputs checked just after edge i.
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      @(negedge clk);
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_addr, tbl[i].d_wdata, tbl[i].d_wmask);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d strobe", i),   32'(bus.o_read_strobe), 32'(tbl[i].e_strobe));
      chk($sformatf("row%0d addr", i),     bus.o_mem_addr, tbl[i].e_addr);
      chk($sformatf("row%0d wdata", i),    bus.o_mem_write_data, tbl[i].e_wdata);
      chk($sformatf("row%0d wmask", i),    32'(bus.o_mem_write_mask), 32'(tbl[i].e_wmask));
      chk($sformatf("row%0d if_ack", i),   32'(bus.o_if_ack), 32'(tbl[i].e_if_ack));
      chk($sformatf("row%0d if_rdata", i), bus.o_if_rdata, tbl[i].e_if_rdata);
      chk($sformatf("row%0d d_ack", i),    32'(bus.o_d_ack), 32'(tbl[i].e_d_ack));
      chk($sformatf("row%0d d_rdata", i),  bus.o_d_rdata, tbl[i].e_d_rdata);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    int          acks [$];
    int          exp_acks [4];

    // fetch 0x100
    tbl[0]  = mk(1, 32'h100, 0, 32'h0, 32'h0, 4'h0,  1, 32'h100, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);
    tbl[1]  = mk(1, 32'h100, 0, 32'h0, 32'h0, 4'h0,  0, 32'h100, 32'h0, 4'h0,  1, 32'h13, 0, 32'h0);
    tbl[2]  = mk(0, 32'h0,   0, 32'h0, 32'h0, 4'h0,  0, 32'h100, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);
    // store 0xDEADBEEF, mask 0011, to 0x400
    tbl[3]  = mk(0, 32'h0, 1, 32'h400, 32'hDEADBEEF, 4'h3,  0, 32'h400, 32'hDEADBEEF, 4'h3,  0, 32'h0, 0, 32'h0);
    tbl[4]  = mk(0, 32'h0, 1, 32'h400, 32'hDEADBEEF, 4'h3,  0, 32'h400, 32'hDEADBEEF, 4'h0,  0, 32'h0, 1, 32'h0);
    tbl[5]  = mk(0, 32'h0, 0, 32'h0,   32'h0,        4'h0,  0, 32'h400, 32'hDEADBEEF, 4'h0,  0, 32'h0, 0, 32'h0);
    // load back 0x400; payload changed after the latch must be ignored
    tbl[6]  = mk(0, 32'h0, 1, 32'h400, 32'h55555555, 4'h0,  1, 32'h400, 32'h55555555, 4'h0,  0, 32'h0, 0, 32'h0);
    tbl[7]  = mk(0, 32'h0, 1, 32'h200, 32'h0,        4'hF,  0, 32'h400, 32'h55555555, 4'h0,  0, 32'h0, 1, 32'h1122BEEF);
    tbl[8]  = mk(0, 32'h0, 0, 32'h0,   32'h0,        4'h0,  0, 32'h400, 32'h55555555, 4'h0,  0, 32'h0, 0, 32'h0);
    // collision: data first, fetch acked 3 cycles later
    tbl[9]  = mk(1, 32'h100, 1, 32'h200, 32'h0, 4'h0,  1, 32'h200, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);
    tbl[10] = mk(1, 32'h100, 1, 32'h200, 32'h0, 4'h0,  0, 32'h200, 32'h0, 4'h0,  0, 32'h0, 1, 32'hCAFEF00D);
    tbl[11] = mk(1, 32'h100, 0, 32'h0,   32'h0, 4'h0,  0, 32'h200, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);
    tbl[12] = mk(1, 32'h100, 0, 32'h0,   32'h0, 4'h0,  1, 32'h100, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);
    tbl[13] = mk(1, 32'h100, 0, 32'h0,   32'h0, 4'h0,  0, 32'h100, 32'h0, 4'h0,  1, 32'h13, 0, 32'h0);
    tbl[14] = mk(0, 32'h0,   0, 32'h0,   32'h0, 4'h0,  0, 32'h100, 32'h0, 4'h0,  0, 32'h0, 0, 32'h0);

    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    run_rows(0, 8);

    // Reset during ISSUE of a load: outputs clear at once, no ack afterwards.
    @(negedge clk);
    drive(0, 32'h0, 1, 32'h300, 32'h0, 4'h0);
    @(posedge clk);
    #1;
    chk("abort load issued", 32'(bus.o_read_strobe), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_zero("async reset");
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("aborted no d_ack c%0d", c), 32'(bus.o_d_ack), 32'h0);
    end
    @(negedge clk);
    drive(1, 32'h104, 0, 32'h0, 32'h0, 4'h0);
    lat = -1;
    rd  = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.o_if_ack) begin
        lat = c;
        rd  = bus.o_if_rdata;
        break;
      end
    end
    chk("post-reset fetch latency", 32'(lat), 32'd2);
    chk("post-reset fetch data", rd, 32'h0010_0093);
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk);

    run_rows(9, 14);

    // Both ports held for 12 cycles.
`ifdef TINY_RISCV_ARB_RR_EN
    exp_acks = '{1, 0, 1, 0};
`else
    exp_acks = '{1, 1, 1, 1};
`endif
    @(negedge clk);
    drive(1, 32'h100, 1, 32'h200, 32'h0, 4'h0);
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold c%0d acks exclusive", c), 32'(bus.o_if_ack & bus.o_d_ack), 32'h0);
      if (bus.o_d_ack) begin
        acks.push_back(1);
        chk($sformatf("hold c%0d d_rdata", c), bus.o_d_rdata, 32'hCAFEF00D);
      end else if (bus.o_if_ack) begin
        acks.push_back(0);
        chk($sformatf("hold c%0d if_rdata", c), bus.o_if_rdata, 32'h13);
      end
    end
    @(negedge clk);
    drive(0, 32'h0, 0, 32'h0, 32'h0, 4'h0);
    chk("hold ack count", 32'(acks.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < acks.size()) chk($sformatf("hold ack%0d port", k), 32'(acks[k]), 32'(exp_acks[k]));
      else                 chk($sformatf("hold ack%0d missing", k), 32'hFFFF_FFFF, 32'(exp_acks[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
